// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU with HI/LO; long ops take DWIDTH+1 cycles, short ops 1.
// No backpressure: busy stalls the pipeline, starts are ignored while an op is in flight.
module mult_div_unit #(
   parameter int DWIDTH    = 32,
   parameter int CNT_WIDTH = 6
) (
   input  logic              md_i_clk,
   input  logic              md_i_rst,
   input  logic              md_i_start,
   input  logic [2:0]        md_i_op,
   input  logic [DWIDTH-1:0] md_i_data_rs,
   input  logic [DWIDTH-1:0] md_i_data_rt,
   input  logic              md_i_flush,
   output logic [DWIDTH-1:0] md_o_hi,
   output logic [DWIDTH-1:0] md_o_lo,
   output logic [DWIDTH-1:0] md_o_value,
   output logic              md_o_busy,
   output logic              md_o_done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   localparam logic [2:0] OP_MFHI = 3'b100;
   localparam logic [2:0] OP_MFLO = 3'b101;
   localparam logic [2:0] OP_MTHI = 3'b110;
   localparam logic [2:0] OP_MTLO = 3'b111;
   localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DWIDTH - 1);

   state_t                state;
   logic [CNT_WIDTH-1:0]  cnt;
   logic                  is_div;
   logic                  neg_res;
   logic                  neg_rem;
   logic                  div_zero;
   logic [DWIDTH-1:0]     rs_keep;
   logic [DWIDTH-1:0]     opb;
   logic [2*DWIDTH-1:0]   acc;
   logic [DWIDTH-1:0]     rem;
   logic [DWIDTH-1:0]     quo;

   logic                  signed_op;
   logic                  rs_neg;
   logic                  rt_neg;
   logic [DWIDTH-1:0]     rs_mag;
   logic [DWIDTH-1:0]     rt_mag;
   logic [DWIDTH:0]       mul_sum;
   logic [2*DWIDTH-1:0]   mul_next;
   logic [DWIDTH:0]       div_trial;
   logic [DWIDTH:0]       div_diff;
   logic [2*DWIDTH-1:0]   prod_fix;
   logic [DWIDTH-1:0]     quo_fix;
   logic [DWIDTH-1:0]     rem_fix;

   always_comb begin
      // MULT and DIV (op[0]=0) are the signed forms
      signed_op = ~md_i_op[0];
      rs_neg    = signed_op & md_i_data_rs[DWIDTH-1];
      rt_neg    = signed_op & md_i_data_rt[DWIDTH-1];
      rs_mag    = rs_neg ? -md_i_data_rs : md_i_data_rs;
      rt_mag    = rt_neg ? -md_i_data_rt : md_i_data_rt;

      // Multiplier sits in acc's low half and is shifted out as partial sums shift in
      mul_sum   = {1'b0, acc[2*DWIDTH-1:DWIDTH]} + (acc[0] ? {1'b0, opb} : '0);
      mul_next  = {mul_sum, acc[DWIDTH-1:1]};

      div_trial = {rem, quo[DWIDTH-1]};
      div_diff  = div_trial - {1'b0, opb};

      prod_fix  = neg_res ? -acc : acc;
      quo_fix   = neg_res ? -quo : quo;
      rem_fix   = neg_rem ? -rem : rem;
   end

   always_ff @(posedge md_i_clk or posedge md_i_rst) begin
      if (md_i_rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         is_div     <= 1'b0;
         neg_res    <= 1'b0;
         neg_rem    <= 1'b0;
         div_zero   <= 1'b0;
         rs_keep    <= '0;
         opb        <= '0;
         acc        <= '0;
         rem        <= '0;
         quo        <= '0;
         md_o_hi    <= '0;
         md_o_lo    <= '0;
         md_o_value <= '0;
         md_o_busy  <= 1'b0;
         md_o_done  <= 1'b0;
      end else if (md_i_flush) begin
         state     <= S_IDLE;
         md_o_busy <= 1'b0;
         md_o_done <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               md_o_done <= 1'b0;
               state     <= S_IDLE;
               if (md_i_start) begin
                  if (md_i_op[2]) begin
                     case (md_i_op)
                        OP_MFHI: md_o_value <= md_o_hi;
                        OP_MFLO: md_o_value <= md_o_lo;
                        OP_MTHI: md_o_hi    <= md_i_data_rs;
                        OP_MTLO: md_o_lo    <= md_i_data_rs;
                        default: ;
                     endcase
                     md_o_done <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     is_div    <= md_i_op[1];
                     neg_res   <= rs_neg ^ rt_neg;
                     neg_rem   <= rs_neg;
                     div_zero  <= (md_i_data_rt == '0);
                     rs_keep   <= md_i_data_rs;
                     cnt       <= '0;
                     md_o_busy <= 1'b1;
                     state     <= S_RUN;
                     if (md_i_op[1]) begin
                        opb <= rt_mag;
                        rem <= '0;
                        quo <= rs_mag;
                     end else begin
                        opb <= rs_mag;
                        acc <= {{DWIDTH{1'b0}}, rt_mag};
                     end
                  end
               end
            end
            S_RUN: begin
               if (is_div) begin
                  if (!div_diff[DWIDTH]) begin
                     rem <= div_diff[DWIDTH-1:0];
                     quo <= {quo[DWIDTH-2:0], 1'b1};
                  end else begin
                     rem <= div_trial[DWIDTH-1:0];
                     quo <= {quo[DWIDTH-2:0], 1'b0};
                  end
               end else begin
                  acc <= mul_next;
               end
               cnt <= cnt + CNT_WIDTH'(1);
               if (cnt == LAST_ITER) state <= S_FIX;
            end
            S_FIX: begin
               if (!is_div) begin
                  {md_o_hi, md_o_lo} <= prod_fix;
               end else if (div_zero) begin
                  md_o_lo <= '1;
                  md_o_hi <= rs_keep;
               end else begin
                  md_o_lo <= quo_fix;
                  md_o_hi <= rem_fix;
               end
               md_o_busy <= 1'b0;
               md_o_done <= 1'b1;
               state     <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
